press_classifier: RTL and testbench

//  Consumes the clean level from the debouncer and turns each press into discrete events.

---
 rtl/press_classifier.sv | 119 +++++++++++
 tb/tb_press_classifier.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/press_classifier.sv
// Classifies debounced key presses into short-press, long-press and auto-repeat events,
// and keeps a wrapping count of short plus long presses.
module press_classifier #(
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250,
  parameter int HOLD_W        = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             clr,
  output logic             short_press,
  output logic             long_press,
  output logic             repeat_tick,
  output logic             held,
  output logic [CNT_W-1:0] press_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_HELD    = 2'd2
  } state_t;

  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  state_t             state_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [HOLD_W-1:0]  rep_cnt_q;
  logic               short_q;
  logic               long_q;
  logic               tick_q;
  logic               held_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               press_evt_d;

  // A press is decided either by release in PRESSED or by reaching the long threshold.
  always_comb begin
    press_evt_d = 1'b0;
    if (state_q == S_PRESSED) begin
      press_evt_d = (!btn) || (hold_cnt_q == LONG_LAST);
    end else begin
      press_evt_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      tick_q     <= 1'b0;
      held_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      short_q <= 1'b0;
      long_q  <= 1'b0;
      tick_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          held_q <= 1'b0;
          if (btn) begin
            state_q    <= S_PRESSED;
            hold_cnt_q <= '0;
          end
        end
        // Release is checked first so it wins over the long threshold on the same edge.
        S_PRESSED: begin
          if (!btn) begin
            state_q <= S_IDLE;
            short_q <= 1'b1;
            held_q  <= 1'b0;
          end else if (hold_cnt_q == LONG_LAST) begin
            state_q   <= S_HELD;
            rep_cnt_q <= '0;
            long_q    <= 1'b1;
            held_q    <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        S_HELD: begin
          if (!btn) begin
            state_q <= S_IDLE;
            held_q  <= 1'b0;
          end else if (rep_cnt_q == REP_LAST) begin
            tick_q    <= 1'b1;
            rep_cnt_q <= '0;
            held_q    <= 1'b1;
          end else begin
            rep_cnt_q <= rep_cnt_q + HOLD_W'(1);
            held_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          held_q  <= 1'b0;
        end
      endcase
      // Clear has priority over a simultaneous press event.
      if (clr) begin
        cnt_q <= '0;
      end else if (press_evt_d) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign short_press = short_q;
  assign long_press  = long_q;
  assign repeat_tick = tick_q;
  assign held        = held_q;
  assign press_cnt   = cnt_q;

endmodule

// File: tb/tb_press_classifier.sv
// Vector-table bench for press_classifier with LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4.
module tb_press_classifier;

  typedef struct {
    logic       r;
    logic       b;
    logic       c;
    logic [7:0] exp;  // {short, long, tick, held, cnt[3:0]}
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       clr = 1'b0;
  logic       short_press, long_press, repeat_tick, held;
  logic [3:0] press_cnt;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;

  press_classifier #(
    .LONG_CYCLES(8), .REPEAT_CYCLES(4), .HOLD_W(16), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .clr(clr),
    .short_press(short_press), .long_press(long_press),
    .repeat_tick(repeat_tick), .held(held), .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  task automatic v(input logic r, input logic b, input logic c,
                   input logic s, input logic l, input logic t, input logic h,
                   input int cnt);
    vec_t x;
    x.r = r; x.b = b; x.c = c;
    x.exp = {s, l, t, h, 4'(cnt)};
    vecs.push_back(x);
  endtask

  // n quiet edges: no pulses, given btn, held level and count
  task automatic quiet(input logic b, input logic h, input int n, input int cnt);
    for (int i = 0; i < n; i++) v(1'b0, b, 1'b0, 1'b0, 1'b0, 1'b0, h, cnt);
  endtask

  // btn=1 for E0..E7 then E8 with btn=1: long press, count becomes cnt_after
  task automatic to_long(input int cnt_before, input int cnt_after);
    quiet(1'b1, 1'b0, 8, cnt_before);
    v(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, cnt_after);
  endtask

  initial begin
    int cnt;
    logic [7:0] got;
    logic [7:0] want;

    // 1: reset held with btn=1, then btn=1 becomes E0; 2: release at E3
    v(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    v(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    quiet(1'b1, 1'b0, 3, 0);
    v(1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 1);
    quiet(1'b0, 1'b0, 1, 1);

    // 3a: release exactly at E8 is still short
    quiet(1'b1, 1'b0, 8, 1);
    v(1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 2);
    quiet(1'b0, 1'b0, 1, 2);

    // 3b: long press at E8, release gives no short
    to_long(2, 3);
    quiet(1'b1, 1'b1, 1, 3);
    quiet(1'b0, 1'b0, 2, 3);

    // 4: held through E20, ticks at E12, E16, E20
    to_long(3, 4);
    for (int k = 0; k < 3; k++) begin
      quiet(1'b1, 1'b1, 3, 4);
      v(1'b0, 1'b1, 1'b0, 0, 0, 1, 1, 4);
    end
    quiet(1'b0, 1'b0, 2, 4);

    // 5: release exactly at E12 suppresses the tick; next press is normal
    to_long(4, 5);
    quiet(1'b1, 1'b1, 3, 5);
    v(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 5);
    quiet(1'b1, 1'b0, 2, 5);
    v(1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 6);
    quiet(1'b0, 1'b0, 1, 6);

    // 6: 16 back-to-back one-edge presses, count wraps 15 -> 0
    cnt = 6;
    for (int k = 0; k < 16; k++) begin
      v(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, cnt);
      cnt = (cnt + 1) % 16;
      v(1'b0, 1'b0, 1'b0, 1, 0, 0, 0, cnt);
    end
    // clr on the releasing edge: pulse survives, count cleared
    v(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 6);
    v(1'b0, 1'b0, 1'b1, 1, 0, 0, 0, 0);
    quiet(1'b0, 1'b0, 1, 0);

    // reset mid-press and mid-hold: no pulses, counter cleared, new E0 after reset
    v(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    v(1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 1);
    quiet(1'b1, 1'b0, 4, 1);
    v(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    to_long(0, 1);
    quiet(1'b1, 1'b1, 2, 1);
    v(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    quiet(1'b1, 1'b0, 3, 0);
    v(1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 1);
    quiet(1'b0, 1'b0, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].r;
      btn = vecs[i].b;
      clr = vecs[i].c;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      got  = {short_press, long_press, repeat_tick, held, press_cnt};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL vec%0d: got s=%0b l=%0b t=%0b h=%0b cnt=%0d, expected s=%0b l=%0b t=%0b h=%0b cnt=%0d",
                 i, got[7], got[6], got[5], got[4], got[3:0],
                 want[7], want[6], want[5], want[4], want[3:0]);
      end
      checks++;
      if ($countones({short_press, long_press, repeat_tick}) > 1) begin
        errors++;
        $display("FAIL onehot vec%0d: pulses=%b, expected at most one high", i,
                 {short_press, long_press, repeat_tick});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
